// File: rtl/pm_arb_pkg.sv
// Shared types and helpers for the packet-manager write-port arbiter.
package pm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_ACK_WAIT = 2'd2,
    ST_GAP      = 2'd3
  } arb_state_e;

  // Ceiling log2, never below 1 so it can always size a vector.
  function automatic int clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while (((32'd1 << w) < value) && (w < 31)) w++;
    return int'(w);
  endfunction

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_select
  import pm_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [ID_W-1:0]    offset;
  logic [ID_W:0]      sum;
  logic               found;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    doubled = {req, req} >> ptr;
    rotated = doubled[N_REQ-1:0];
    offset  = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && rotated[i]) begin
        offset = ID_W'(i);
        found  = 1'b1;
      end
    end
    sum = {1'b0, offset} + {1'b0, ptr};
    if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
    winner = sum[ID_W-1:0];
    valid  = |req;
  end

endmodule

// File: rtl/pm_arbiter.sv
// Round-robin arbiter sharing the command FIFO write port between packet managers.
module pm_arbiter
  import pm_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         arb_request,
  input  logic [N_REQ-1:0]         arb_ack,
  output logic [N_REQ-1:0]         arb_grant,
  input  logic                     fifo_wr_ready,
  output logic                     busy,
  output logic [clog2(N_REQ)-1:0]  last_id,
  output logic                     timeout_err,
  output logic [CNT_WIDTH-1:0]     grant_count,
  output logic [CNT_WIDTH-1:0]     miss_count,
  output logic [CNT_WIDTH-1:0]     timeout_count
);

  localparam int ID_W   = clog2(N_REQ);
  localparam int WAIT_W = clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W  = clog2(GAP_CYCLES + 1);
  localparam arb_state_e DONE_STATE = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
  localparam logic       DONE_BUSY  = (GAP_CYCLES != 0);

  arb_state_e        state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   sel_id;
  logic              sel_valid;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  rr_select #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_select (
    .req    (arb_request),
    .ptr    (ptr),
    .winner (sel_id),
    .valid  (sel_valid)
  );

  // Grant FSM with its wait/gap counters and the statistics counters.
  // wait_cnt counts the GRANT cycle as 1, so the same timeout compare serves
  // both GRANT and ACK_WAIT (covers ACK_TIMEOUT=1 without a special case).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      wait_cnt      <= '0;
      gap_cnt       <= '0;
      arb_grant     <= '0;
      busy          <= 1'b0;
      last_id       <= '0;
      timeout_err   <= 1'b0;
      grant_count   <= '0;
      miss_count    <= '0;
      timeout_count <= '0;
    end else begin
      arb_grant   <= '0;
      timeout_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (sel_valid && fifo_wr_ready) begin
            state       <= ST_GRANT;
            busy        <= 1'b1;
            arb_grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_id;
            last_id     <= sel_id;
            ptr         <= (sel_id == ID_W'(N_REQ-1)) ? '0 : sel_id + ID_W'(1);
            wait_cnt    <= WAIT_W'(1);
            grant_count <= CNT_WIDTH'(sat_inc(64'(grant_count), CNT_WIDTH));
          end
        end
        ST_GRANT, ST_ACK_WAIT: begin
          if ((state == ST_GRANT) && !fifo_wr_ready)
            miss_count <= CNT_WIDTH'(sat_inc(64'(miss_count), CNT_WIDTH));
          if (arb_ack[last_id]) begin
            state   <= DONE_STATE;
            busy    <= DONE_BUSY;
            gap_cnt <= GAP_W'(1);
          end else if (wait_cnt >= WAIT_W'(ACK_TIMEOUT)) begin
            state         <= DONE_STATE;
            busy          <= DONE_BUSY;
            gap_cnt       <= GAP_W'(1);
            timeout_err   <= 1'b1;
            timeout_count <= CNT_WIDTH'(sat_inc(64'(timeout_count), CNT_WIDTH));
          end else begin
            state    <= ST_ACK_WAIT;
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt >= GAP_W'(GAP_CYCLES)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pm_arbiter.sv
// Scoreboard bench for pm_arbiter: driver pushes expectations, monitor checks.
module tb_pm_arbiter;

  localparam int N   = 4;
  localparam int GAP = 1;
  localparam int TO  = 15;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  arb_request;
  logic [N-1:0]  arb_ack;
  logic [N-1:0]  arb_grant;
  logic          fifo_wr_ready;
  logic          busy;
  logic [1:0]    last_id;
  logic          timeout_err;
  logic [CW-1:0] grant_count;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] timeout_count;

  pm_arbiter #(
    .N_REQ       (N),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (TO),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .arb_request   (arb_request),
    .arb_ack       (arb_ack),
    .arb_grant     (arb_grant),
    .fifo_wr_ready (fifo_wr_ready),
    .busy          (busy),
    .last_id       (last_id),
    .timeout_err   (timeout_err),
    .grant_count   (grant_count),
    .miss_count    (miss_count),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned id;
    longint      cyc;
    longint      gc;
    longint      miss;
  } grant_exp_t;

  typedef struct {
    longint cyc;
    longint tc;
  } to_exp_t;

  grant_exp_t gq[$];
  to_exp_t    tq[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state: pointer and event counts.
  int unsigned m_ptr  = 0;
  longint      m_gc   = 0;
  longint      m_miss = 0;
  longint      m_tc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned model_pick(input logic [N-1:0] req, input int unsigned ptr);
    for (int unsigned k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  // Record the grant the model says the next arbitration produces.
  task automatic expect_grant(input logic [N-1:0] req, input longint at_cyc, output int unsigned id);
    grant_exp_t e;
    id = model_pick(req, m_ptr);
    m_gc++;
    e.id = id; e.cyc = at_cyc; e.gc = m_gc; e.miss = m_miss;
    gq.push_back(e);
    m_ptr = (id + 1) % N;
  endtask

  // Monitor: compares every grant and timeout pulse against the queues.
  always @(negedge clk) begin : monitor
    grant_exp_t ge;
    to_exp_t    te;
    if (rst === 1'b1) begin
      if (arb_grant !== '0) begin
        if (gq.size() == 0) check("unexpected_grant", 64'(arb_grant), 64'd0);
        else begin
          ge = gq.pop_front();
          check("grant_vec",   64'(arb_grant),   64'd1 << ge.id);
          check("grant_id",    64'(last_id),     64'(ge.id));
          check("grant_cycle", 64'(cyc),         64'(ge.cyc));
          check("grant_count", 64'(grant_count), 64'(ge.gc));
          check("miss_count",  64'(miss_count),  64'(ge.miss));
          check("grant_busy",  64'(busy),        64'd1);
        end
      end
      if (timeout_err !== 1'b0) begin
        if (tq.size() == 0) check("unexpected_timeout", 64'(timeout_err), 64'd0);
        else begin
          te = tq.pop_front();
          check("timeout_cycle", 64'(cyc),           64'(te.cyc));
          check("timeout_count", 64'(timeout_count), 64'(te.tc));
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    check("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic wait_grant(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (arb_grant != '0) begin
        seen = 1'b1;
        return;
      end
    end
    check("grant_wait", 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},  64'(arb_grant),     64'd0);
    check({tag, "_busy"},   64'(busy),          64'd0);
    check({tag, "_lastid"}, 64'(last_id),       64'd0);
    check({tag, "_toerr"},  64'(timeout_err),   64'd0);
    check({tag, "_gcnt"},   64'(grant_count),   64'd0);
    check({tag, "_mcnt"},   64'(miss_count),    64'd0);
    check({tag, "_tcnt"},   64'(timeout_count), 64'd0);
  endtask

  // One transaction: request, optional ready delay, ack after ack_k cycles
  // (ack_k >= TO means the granted manager never acknowledges in time).
  task automatic txn(input logic [N-1:0] req, input int unsigned ready_delay,
                     input int unsigned ack_k, input bit drop_ready, input logic [N-1:0] other_ack);
    int unsigned id;
    bit          seen;
    longint      g;
    to_exp_t     te;
    wait_idle();
    arb_request   = req;
    fifo_wr_ready = 1'b0;
    repeat (ready_delay) @(negedge clk);
    fifo_wr_ready = 1'b1;
    expect_grant(req, cyc + 1, id);
    wait_grant(seen);
    if (!seen) begin
      arb_request = '0; fifo_wr_ready = 1'b0;
      wait_idle();
      return;
    end
    g = cyc;
    if (drop_ready) begin
      fifo_wr_ready = 1'b0;
      m_miss++;
    end
    arb_ack = other_ack & ~(N'(1) << id);
    if (ack_k == 0) arb_ack[id] = 1'b1;
    if (ack_k >= TO) begin
      m_tc++;
      te.cyc = g + TO; te.tc = m_tc;
      tq.push_back(te);
    end
    for (int unsigned t = 1; t < 60; t++) begin
      @(negedge clk);
      if (!busy) break;
      if (t == ack_k) arb_ack[id] = 1'b1;
      fifo_wr_ready = 1'($urandom_range(0, 1));
    end
    arb_request   = '0;
    arb_ack       = '0;
    fifo_wr_ready = 1'b0;
  endtask

  initial begin : driver
    longint      c;
    int unsigned id;
    bit          seen;
    logic [N-1:0] r;

    rst = 1'b0; arb_request = '1; arb_ack = '0; fifo_wr_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset");
    end
    arb_request = '0; fifo_wr_ready = 1'b0; rst = 1'b1;
    @(negedge clk);

    // All requesting, ack tied high: 0,1,2,3,0 at 3-cycle spacing.
    arb_request = '1; arb_ack = '1; fifo_wr_ready = 1'b1;
    c = cyc;
    for (int i = 0; i < 5; i++) expect_grant('1, c + 1 + 3 * i, id);
    repeat (13) @(negedge clk);
    arb_request = '0;
    wait_idle();
    check("rr_grant_total", 64'(grant_count), 64'd5);
    arb_ack = '0; fifo_wr_ready = 1'b0;

    // Ready held low 10 cycles, then grant follows one cycle later.
    txn(4'b0100, 10, 0, 1'b0, '0);
    // Never acknowledged while every other manager acks: timeout, then next grant.
    txn(4'($urandom_range(1, 15)), 0, 99, 1'b0, '1);
    txn(4'($urandom_range(1, 15)), 0, 0, 1'b0, '0);
    // Ack on the last allowed cycle wins; one later is a timeout.
    txn(4'($urandom_range(1, 15)), 0, TO - 1, 1'b0, '0);
    txn(4'($urandom_range(1, 15)), 0, TO, 1'b0, '0);
    // Ready drops during the grant cycle.
    txn(4'($urandom_range(1, 15)), 1, 0, 1'b1, '0);

    // Reset during ACK_WAIT aborts and clears everything.
    wait_idle();
    r = 4'($urandom_range(1, 15));
    arb_request = r; fifo_wr_ready = 1'b1;
    expect_grant(r, cyc + 1, id);
    wait_grant(seen);
    arb_ack = '0;
    repeat (5) @(negedge clk);
    check("busy_in_ack_wait", 64'(busy), 64'd1);
    rst = 1'b0; arb_request = '0; fifo_wr_ready = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b1;
    m_ptr = 0; m_gc = 0; m_miss = 0; m_tc = 0;
    @(negedge clk);
    txn(4'($urandom_range(1, 15)), 0, 0, 1'b0, '0);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      int unsigned sel;
      int unsigned k;
      sel = $urandom_range(0, 9);
      k = (sel < 5) ? 0 : (sel < 9) ? $urandom_range(1, TO + 1) : 99;
      txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), k,
          ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("grant_queue_drained",   64'(gq.size()),     64'd0);
    check("timeout_queue_drained", 64'(tq.size()),     64'd0);
    check("final_grant_count",     64'(grant_count),   64'(m_gc));
    check("final_miss_count",      64'(miss_count),    64'(m_miss));
    check("final_timeout_count",   64'(timeout_count), 64'(m_tc));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
